relu_maxpool: RTL and testbench
===============================

// Module: relu_maxpool
// PURPOSE
//  Downstream stage of the npcnn convolution engine: consumes the 20-bit signed conv outputs in raster order,
//  applies ReLU, performs non-overlapping POOLxPOOL max pooling, and emits pooled values in raster order.
//  Pooling runs on the fly with a single-row running-max buffer; the full feature map is never stored.
// PARAMETERS
//  A_SIZE       6   input image side of the upstream conv stage
//  F_SIZE       3   filter side of the upstream conv stage
//  STRIDE       1   conv stride of the upstream stage
//  ZEROPADDING  0   conv zero padding of the upstream stage
//  POOL         2   pooling window side and pooling stride (>=2)
//  derived: FMAP=(A_SIZE-F_SIZE+2*ZEROPADDING)/STRIDE+1 (default 4); OSZ=FMAP/POOL (default 2)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  go         in   1   start one feature map; sampled only in IDLE or DONE
//  in_data    in   20  signed two's-complement conv output
//  in_valid   in   1   in_data valid this cycle; exactly FMAP*FMAP strobes per map, raster order
//  pool_out   out  20  pooled value, unsigned, MSB always 0
//  pool_valid out  1   pool_out valid; one-cycle pulse per pooled value
//  done       out  1   map complete; held high in DONE until the next go
// BEHAVIOUR
//  Reset (reset=0, any time, including mid-map): state=IDLE, counters=0, buffer=0, pool_out=0,
//   pool_valid=0, done=0. No partial output is emitted after reset is released.
//  FSM states: IDLE, RUN, DONE.
//   IDLE --go--> RUN (clear row/col counters); DONE --go--> RUN (done drops in the same edge).
//   RUN --last input accepted (r=FMAP-1, c=FMAP-1)--> DONE.
//   go in RUN is ignored. in_valid in IDLE or DONE is ignored. When go and in_valid arrive in the same cycle
//    in IDLE or DONE, that in_valid is dropped.
//  Counters: c increments on each accepted in_valid and wraps 0 at FMAP-1, where r increments.
//   Gaps (in_valid=0) freeze all state.
//  ReLU: v = in_data[19] ? 0 : in_data (20-bit, unsigned thereafter).
//  Window index: w=c/POOL. Positions with r>=OSZ*POOL or c>=OSZ*POOL (odd remainder) are accepted and
//   counted but do not touch the buffer (floor pooling).
//  Buffer buf[0..OSZ-1], 20 bits each:
//   first element of a window (r%POOL==0 && c%POOL==0): buf[w] <= v (load, no compare).
//   otherwise: buf[w] <= max(buf[w], v) (unsigned compare; a tie keeps buf[w]).
//  Emit: on the last element of a window (r%POOL==POOL-1 && c%POOL==POOL-1), pool_out <= max(buf[w], v) and
//   pool_valid=1 on the next cycle. Latency is 1 clk from that in_valid edge. pool_out holds its value between pulses.
//  done rises in the cycle after the transition into DONE, coincident with the final pool_valid when
//   FMAP is divisible by POOL. Outputs per map: OSZ*OSZ, row-major order.
// STRUCTURE
//  Shared header cnn_params.vh: DATA_W=20 and the FMAP formula, also used by the conv datapath.
//  One sub-module: pool_window_buf, holding the OSZ-entry running-max register array with load/max/read
//   by index w. The FSM, counters, ReLU and emit logic stay in relu_maxpool.
// TESTING
//  1 default params, go, then 16 inputs 1..16 raster -> pool_valid x4: 6,8,14,16; then done=1.
//  2 all inputs negative (-5, 0xFFFFB) -> four outputs, all 0; MSB of pool_out never 1.
//  3 map 1..16 with in_valid gaps of 0-3 random cycles -> same outputs and order as test 1; state frozen in gaps.
//  4 reset low after the 6th input, release, go, then a full map of all 7 -> four outputs of 7, no stale value.
//  5 A_SIZE=7 (FMAP=5), inputs 0..24 -> outputs 6,8,16,18; row 4 and col 4 ignored; done after the 25th input.
//  6 go during RUN and in_valid in DONE -> no effect; a second go from DONE with a new map -> correct new outputs.

Source files
------------

// File: rtl/relu_maxpool_pkg.sv
// ---------------------------------------------------------------------------
// relu_maxpool_pkg
//   Shared definitions for the ReLU + max-pool stage of the npcnn engine:
//   data width, FSM state encodings, the conv feature-map size formula and
//   small datapath helpers (ReLU clamp, unsigned max with tie-keeps-first).
// ---------------------------------------------------------------------------
package relu_maxpool_pkg;

  localparam int DATA_W = 20;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Side of the feature map produced by the upstream conv stage
  function automatic int fmap_size(input int a_size, input int f_size,
                                   input int stride, input int zeropadding);
    return (a_size - f_size + 2 * zeropadding) / stride + 1;
  endfunction

  // ReLU: negative values clamp to zero, result is treated as unsigned
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? {DATA_W{1'b0}} : x;
  endfunction

  // Unsigned max; on a tie the first operand (the stored value) is kept
  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// ---------------------------------------------------------------------------
// relu_maxpool_if
//   Stream interface of the ReLU + max-pool stage.
//   go         : start one feature map
//   in_data    : signed conv output, in_valid qualifies it
//   pool_out   : pooled value (unsigned), pool_valid one-cycle pulse
//   done       : map complete, held until the next go
//   master = producer/consumer side (conv engine / bench), slave = pool stage.
// ---------------------------------------------------------------------------
interface relu_maxpool_if;

  logic                                go;
  logic [relu_maxpool_pkg::DATA_W-1:0] in_data;
  logic                                in_valid;
  logic [relu_maxpool_pkg::DATA_W-1:0] pool_out;
  logic                                pool_valid;
  logic                                done;

  modport master (
    output go, in_data, in_valid,
    input  pool_out, pool_valid, done
  );

  modport slave (
    input  go, in_data, in_valid,
    output pool_out, pool_valid, done
  );

endinterface

// File: rtl/relu_maxpool_pool_window_buf.sv
// ---------------------------------------------------------------------------
// pool_window_buf
//   Single-row running-max buffer: one register per pooling window across a
//   feature-map row. An entry selected by idx is either loaded (first element
//   of a window) or updated with the unsigned max of itself and din.
//   Ports: clk, reset (async, active-low), load, upd, idx, din, rd_data
//   (combinational read of the entry selected by idx).
// ---------------------------------------------------------------------------
module pool_window_buf
  import relu_maxpool_pkg::*;
#(
  parameter int OSZ = 2,
  parameter int WW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              upd,
  input  logic [WW-1:0]     idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [OSZ];

  // Entry storage: load or running-max update of the indexed window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OSZ; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < OSZ; i++) begin
        if (idx == WW'(i)) begin
          if (load) begin
            mem_r[i] <= din;
          end else if (upd) begin
            mem_r[i] <= umax(mem_r[i], din);
          end
        end
      end
    end
  end

  // Read mux; an index beyond the last window reads as zero
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    for (int i = 0; i < OSZ; i++) begin
      if (idx == WW'(i)) begin
        rd_data = mem_r[i];
      end else begin
        rd_data = rd_data;
      end
    end
  end

endmodule

// File: rtl/relu_maxpool.sv
// ---------------------------------------------------------------------------
// relu_maxpool
//   Consumes 20-bit signed conv outputs in raster order, applies ReLU and
//   non-overlapping POOLxPOOL max pooling on the fly, and emits pooled values
//   in raster order. Only one row of running maxima is stored.
//   Ports: clk, reset (async, active-low), bus (relu_maxpool_if.slave:
//   go, in_data, in_valid in; pool_out, pool_valid, done out).
//   Rows/columns beyond OSZ*POOL are counted but never pooled (floor pooling).
// ---------------------------------------------------------------------------
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int A_SIZE      = 6,
  parameter int F_SIZE      = 3,
  parameter int STRIDE      = 1,
  parameter int ZEROPADDING = 0,
  parameter int POOL        = 2
) (
  input  logic           clk,
  input  logic           reset,
  relu_maxpool_if.slave  bus
);

  localparam int          FMAP   = fmap_size(A_SIZE, F_SIZE, STRIDE, ZEROPADDING);
  localparam int          OSZ    = FMAP / POOL;
  localparam int          CW     = (FMAP > 1) ? $clog2(FMAP) : 1;
  localparam int          WW     = (OSZ > 1) ? $clog2(OSZ) : 1;
  localparam int unsigned POOL_U = POOL;
  localparam int unsigned SPAN_U = OSZ * POOL;
  localparam logic [CW-1:0] LAST_IDX = CW'(FMAP - 1);

  logic [1:0]        state_r;
  logic [CW-1:0]     row_r;
  logic [CW-1:0]     col_r;
  logic [DATA_W-1:0] pool_out_r;
  logic              pool_valid_r;
  logic              done_r;

  logic [31:0]       row_u_s;
  logic [31:0]       col_u_s;
  logic              accept_s;
  logic              in_win_s;
  logic              first_s;
  logic              last_s;
  logic              last_in_s;
  logic              load_s;
  logic              upd_s;
  logic              emit_s;
  logic [WW-1:0]     win_idx_s;
  logic [DATA_W-1:0] v_s;
  logic [DATA_W-1:0] buf_rd_s;

  // Input decode: acceptance, window position and buffer controls
  always_comb begin
    row_u_s   = {{(32-CW){1'b0}}, row_r};
    col_u_s   = {{(32-CW){1'b0}}, col_r};
    accept_s  = (state_r == ST_RUN) && bus.in_valid;
    in_win_s  = (row_u_s < SPAN_U) && (col_u_s < SPAN_U);
    first_s   = ((row_u_s % POOL_U) == 32'd0) && ((col_u_s % POOL_U) == 32'd0);
    last_s    = ((row_u_s % POOL_U) == (POOL_U - 32'd1)) &&
                ((col_u_s % POOL_U) == (POOL_U - 32'd1));
    last_in_s = (row_r == LAST_IDX) && (col_r == LAST_IDX);
    win_idx_s = WW'(col_u_s / POOL_U);
    v_s       = relu(bus.in_data);
    load_s    = accept_s && in_win_s && first_s;
    upd_s     = accept_s && in_win_s && !first_s;
    emit_s    = accept_s && in_win_s && last_s;
  end

  pool_window_buf #(
    .OSZ (OSZ),
    .WW  (WW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .upd     (upd_s),
    .idx     (win_idx_s),
    .din     (v_s),
    .rd_data (buf_rd_s)
  );

  // FSM and raster counters; gaps in in_valid leave everything frozen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      row_r   <= {CW{1'b0}};
      col_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // in_valid here is dropped, even when it coincides with go
          if (bus.go) begin
            state_r <= ST_RUN;
            row_r   <= {CW{1'b0}};
            col_r   <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (col_r == LAST_IDX) begin
              col_r <= {CW{1'b0}};
              if (row_r == LAST_IDX) begin
                row_r   <= {CW{1'b0}};
                state_r <= ST_DONE;
              end else begin
                row_r <= row_r + CW'(1);
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          row_r   <= {CW{1'b0}};
          col_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Registered outputs: pooled value pulse and map-complete flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pool_out_r   <= {DATA_W{1'b0}};
      pool_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      pool_valid_r <= emit_s;
      if (emit_s) begin
        // the window's final element is compared directly, not via the buffer
        pool_out_r <= umax(buf_rd_s, v_s);
      end
      if (accept_s && last_in_s) begin
        done_r <= 1'b1;
      end else if ((state_r == ST_DONE) && bus.go) begin
        done_r <= 1'b0;
      end
    end
  end

  assign bus.pool_out   = pool_out_r;
  assign bus.pool_valid = pool_valid_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_relu_maxpool.sv
// ---------------------------------------------------------------------------
// tb_relu_maxpool
//   Self-checking bench: dut0 uses default parameters (FMAP=4), dut5 uses
//   A_SIZE=7 (FMAP=5). Expected pooled values are pushed to a per-DUT queue
//   as stimulus is driven and popped by a monitor on each pool_valid pulse.
// ---------------------------------------------------------------------------
module tb_relu_maxpool;
  import relu_maxpool_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  relu_maxpool_if bus0();
  relu_maxpool_if bus5();

  relu_maxpool #(.A_SIZE(6), .F_SIZE(3), .STRIDE(1), .ZEROPADDING(0), .POOL(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  relu_maxpool #(.A_SIZE(7), .F_SIZE(3), .STRIDE(1), .ZEROPADDING(0), .POOL(2)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5));

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] q0[$];
  logic [19:0] q5[$];

  typedef struct {
    logic [15:0][19:0] data;
    logic [3:0][19:0]  exp;
    int                maxgap;
  } map_vec_t;

  map_vec_t tv[4];

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic push(input int d, input logic [19:0] x);
    if (d == 0) q0.push_back(x);
    else q5.push_back(x);
  endtask

  // one clock cycle of stimulus on the selected DUT
  task automatic drive(input int d, input logic [19:0] data, input logic vld, input logic g);
    if (d == 0) begin
      bus0.in_data = data; bus0.in_valid = vld; bus0.go = g;
    end else begin
      bus5.in_data = data; bus5.in_valid = vld; bus5.go = g;
    end
    @(posedge clk); #1;
    if (d == 0) begin
      bus0.in_valid = 1'b0; bus0.go = 1'b0;
    end else begin
      bus5.in_valid = 1'b0; bus5.go = 1'b0;
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (bus0.pool_valid === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0_extra_pulse: got pool_out=%h, required no pulse", bus0.pool_out);
      end else begin
        check("dut0_pool_out", bus0.pool_out, q0.pop_front());
        check("dut0_msb", {19'd0, bus0.pool_out[19]}, 20'd0);
      end
    end
    if (bus5.pool_valid === 1'b1) begin
      if (q5.size() == 0) begin
        n_checks++;
        $display("FAIL dut5_extra_pulse: got pool_out=%h, required no pulse", bus5.pool_out);
      end else begin
        check("dut5_pool_out", bus5.pool_out, q5.pop_front());
      end
    end
  end

  initial begin
    logic [3:0][19:0] e6;

    // vector table
    for (int k = 0; k < 16; k++) begin
      tv[0].data[k] = 20'(k + 1);
      tv[1].data[k] = 20'hFFFFB;
      tv[2].data[k] = 20'(k + 1);
    end
    tv[0].exp = {20'd16, 20'd14, 20'd8, 20'd6};    tv[0].maxgap = 0;
    tv[1].exp = {20'd0, 20'd0, 20'd0, 20'd0};      tv[1].maxgap = 0;
    tv[2].exp = {20'd16, 20'd14, 20'd8, 20'd6};    tv[2].maxgap = 3;
    tv[3].data = {20'd100, 20'd99, 20'd0, 20'd0,
                  20'd99, 20'd100, 20'd0, 20'd0,
                  20'd0, 20'h7FFFE, 20'hFFFF9, 20'd3,
                  20'h80000, 20'h7FFFF, 20'd3, 20'hFFFFF};
    tv[3].exp = {20'd100, 20'd0, 20'h7FFFF, 20'd3}; tv[3].maxgap = 0;

    bus0.go = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = 20'd0;
    bus5.go = 1'b0; bus5.in_valid = 1'b0; bus5.in_data = 20'd0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pool_out", bus0.pool_out, 20'd0);
    check("rst_pool_valid", {19'd0, bus0.pool_valid}, 20'd0);
    check("rst_done", {19'd0, bus0.done}, 20'd0);
    check("rst_done5", {19'd0, bus5.done}, 20'd0);
    reset = 1'b1;
    drive(0, 20'd0, 1'b0, 1'b0);

    // table-driven full maps (tests 1, 2, 3 and a mixed/tie/boundary map)
    for (int t = 0; t < 4; t++) begin
      drive(0, 20'd0, 1'b0, 1'b1);
      check("done_low_after_go", {19'd0, bus0.done}, 20'd0);
      for (int k = 0; k < 16; k++) begin
        if (tv[t].maxgap > 0) begin
          repeat ($urandom_range(tv[t].maxgap, 0)) drive(0, 20'd0, 1'b0, 1'b0);
        end
        if (((k / 4) % 2 == 1) && ((k % 4) % 2 == 1)) push(0, tv[t].exp[(k / 8) * 2 + (k % 4) / 2]);
        drive(0, tv[t].data[k], 1'b1, 1'b0);
      end
      check("done_after_map", {19'd0, bus0.done}, 20'd1);
      drive(0, 20'd0, 1'b0, 1'b0);
      drive(0, 20'd0, 1'b0, 1'b0);
      check("q0_drained", 20'(q0.size()), 20'd0);
      check("pool_out_hold", bus0.pool_out, tv[t].exp[3]);
    end

    // reset in the middle of a map
    drive(0, 20'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) push(0, 20'd6);
      drive(0, 20'(k + 1), 1'b1, 1'b0);
    end
    drive(0, 20'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    check("midrst_pool_out", bus0.pool_out, 20'd0);
    check("midrst_pool_valid", {19'd0, bus0.pool_valid}, 20'd0);
    check("midrst_done", {19'd0, bus0.done}, 20'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 20'd9, 1'b1, 1'b0);
    drive(0, 20'd9, 1'b1, 1'b0);
    drive(0, 20'd0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (((k / 4) % 2 == 1) && ((k % 4) % 2 == 1)) push(0, 20'd7);
      drive(0, 20'd7, 1'b1, 1'b0);
    end
    check("rst_map_done", {19'd0, bus0.done}, 20'd1);
    drive(0, 20'd0, 1'b0, 1'b0);
    drive(0, 20'd0, 1'b0, 1'b0);
    check("rst_map_drained", 20'(q0.size()), 20'd0);

    // go during RUN is ignored
    e6 = {20'd16, 20'd14, 20'd8, 20'd6};
    drive(0, 20'd0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (((k / 4) % 2 == 1) && ((k % 4) % 2 == 1)) push(0, e6[(k / 8) * 2 + (k % 4) / 2]);
      drive(0, 20'(k + 1), 1'b1, (k == 3) || (k == 10));
    end
    check("run_go_done", {19'd0, bus0.done}, 20'd1);
    // in_valid in DONE is ignored
    repeat (3) drive(0, 20'd1000, 1'b1, 1'b0);
    check("done_hold", {19'd0, bus0.done}, 20'd1);
    check("done_no_out", bus0.pool_out, 20'd16);
    // go from DONE with a coincident in_valid that is dropped
    drive(0, 20'd999, 1'b1, 1'b1);
    check("done_drop_go", {19'd0, bus0.done}, 20'd0);
    e6 = {20'd6, 20'd8, 20'd14, 20'd16};
    for (int k = 0; k < 16; k++) begin
      if (((k / 4) % 2 == 1) && ((k % 4) % 2 == 1)) push(0, e6[(k / 8) * 2 + (k % 4) / 2]);
      drive(0, 20'(16 - k), 1'b1, 1'b0);
    end
    check("second_map_done", {19'd0, bus0.done}, 20'd1);
    drive(0, 20'd0, 1'b0, 1'b0);
    drive(0, 20'd0, 1'b0, 1'b0);
    check("second_map_drained", 20'(q0.size()), 20'd0);
    check("second_map_hold", bus0.pool_out, 20'd6);

    // FMAP=5: last row and column are counted but not pooled
    drive(1, 20'd0, 1'b0, 1'b1);
    for (int k = 0; k < 25; k++) begin
      if ((k == 6) || (k == 8) || (k == 16) || (k == 18)) push(1, 20'(k));
      drive(1, 20'(k), 1'b1, 1'b0);
      if (k == 23) check("fmap5_not_done", {19'd0, bus5.done}, 20'd0);
    end
    check("fmap5_done", {19'd0, bus5.done}, 20'd1);
    drive(1, 20'd0, 1'b0, 1'b0);
    drive(1, 20'd0, 1'b0, 1'b0);
    check("q5_drained", 20'(q5.size()), 20'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
